matmul_result_drain: RTL and testbench

Downstream stage of the MxN MAC datapath. When the controller signals that the accumulators hold the final C matrix, this block snapshots C into shadow registers. It then streams the elements out in row-major order on an AXI4-Stream-style master port (valid/ready/last), saturating or sign-extending each element to the output width. The MAC array can be cleared and reused as soon as the snapshot is taken.

---
 rtl/matmul_pkg.sv | 20 ++
 rtl/matmul_result_drain_acc_saturate.sv | 36 +++
 rtl/matmul_result_drain.sv | 138 +++++++++++++
 tb/tb_matmul_result_drain.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matmul result-drain path: FSM state type,
// index-width calculation and signed saturation limits for a given output width.
package matmul_pkg;

  typedef enum logic {DRAIN_IDLE, DRAIN_STREAM} drain_state_t;

  // One spare bit so the index can count one past the last element without wrapping.
  function automatic int idx_w(input int m, input int n);
    return $clog2(m * n) + 1;
  endfunction

  function automatic logic signed [63:0] sat_hi(input int out_w);
    return (64'sd1 <<< (out_w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_lo(input int out_w);
    return -(64'sd1 <<< (out_w - 1));
  endfunction

endpackage

// File: rtl/matmul_result_drain_acc_saturate.sv
// Combinational width converter for one accumulator element: sign-extends when
// widening, clamps to the signed output range when narrowing and flags the clamp.
module acc_saturate
  import matmul_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int OUT_W = 32
) (
  input  logic [ACC_W-1:0] acc,
  output logic [OUT_W-1:0] res,
  output logic             sat
);

  generate
    if (OUT_W >= ACC_W) begin : g_extend
      assign res = OUT_W'($signed(acc));
      assign sat = 1'b0;
    end else begin : g_clamp
      localparam logic signed [ACC_W-1:0] HI = ACC_W'(sat_hi(OUT_W));
      localparam logic signed [ACC_W-1:0] LO = ACC_W'(sat_lo(OUT_W));

      always_comb begin
        res = acc[OUT_W-1:0];
        sat = 1'b0;
        if ($signed(acc) > HI) begin
          res = HI[OUT_W-1:0];
          sat = 1'b1;
        end else if ($signed(acc) < LO) begin
          res = LO[OUT_W-1:0];
          sat = 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/matmul_result_drain.sv
// Snapshots the final MxN accumulator matrix and streams it row-major on an
// AXI4-Stream master, converting each element to the signed output width.
module matmul_result_drain
  import matmul_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int OUT_W = 32,
  parameter int M     = 2,
  parameter int N     = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [M-1:0][N-1:0][ACC_W-1:0]    C,
  output logic                              busy,
  output logic                              snap_done,
  output logic [OUT_W-1:0]                  m_axis_tdata,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic                              done,
  output logic                              sat_flag
);

  localparam int NUM   = M * N;
  localparam int IDX_W = idx_w(M, N);

  drain_state_t     state, state_nxt;
  logic [IDX_W-1:0] idx, idx_inc;
  logic [ACC_W-1:0] c_flat [NUM];
  logic [ACC_W-1:0] shadow [NUM];
  logic [NUM-1:0]   elem_sat;
  logic [OUT_W-1:0] elem_unused [NUM];
  logic [ACC_W-1:0] conv_in;
  logic [OUT_W-1:0] conv_out;
  logic             conv_sat_unused;
  logic             capture, advance, finish, is_last;

  // Saturation detectors see C directly so sat_flag is ready with the snapshot;
  // only their sat bits are consumed.
  for (genvar i = 0; i < M; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      assign c_flat[i*N+j] = C[i][j];
      acc_saturate #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_detect (
        .acc (C[i][j]),
        .res (elem_unused[i*N+j]),
        .sat (elem_sat[i*N+j])
      );
    end
  end

  // tdata is registered, so the converter looks one element ahead: C[0][0] on
  // capture, the next shadow element on each handshake.
  always_comb begin
    idx_inc = idx + 1'b1;
    conv_in = c_flat[0];
    if (state == DRAIN_STREAM) begin
      for (int k = 0; k < NUM; k++) begin
        if (idx_inc == IDX_W'(k)) conv_in = shadow[k];
      end
    end
  end

  acc_saturate #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_conv (
    .acc (conv_in),
    .res (conv_out),
    .sat (conv_sat_unused)
  );

  assign is_last = (idx == IDX_W'(NUM - 1));

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    advance   = 1'b0;
    finish    = 1'b0;
    case (state)
      DRAIN_IDLE: begin
        if (start) begin
          capture   = 1'b1;
          state_nxt = DRAIN_STREAM;
        end
      end
      DRAIN_STREAM: begin
        if (m_axis_tvalid && m_axis_tready) begin
          advance = 1'b1;
          if (is_last) begin
            finish    = 1'b1;
            state_nxt = DRAIN_IDLE;
          end
        end
      end
      default: state_nxt = DRAIN_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DRAIN_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy          <= 1'b0;
      snap_done     <= 1'b0;
      done          <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      sat_flag      <= 1'b0;
      idx           <= '0;
    end else begin
      snap_done     <= capture;
      done          <= finish;
      busy          <= (state_nxt == DRAIN_STREAM);
      m_axis_tvalid <= (state_nxt == DRAIN_STREAM);
      if (capture) begin
        idx          <= '0;
        m_axis_tlast <= 1'(NUM == 1);
        m_axis_tdata <= conv_out;
        sat_flag     <= |elem_sat;
      end else if (advance) begin
        idx          <= idx_inc;
        m_axis_tlast <= (idx_inc == IDX_W'(NUM - 1));
        if (!finish) m_axis_tdata <= conv_out;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM; k++) shadow[k] <= '0;
    end else if (capture) begin
      for (int k = 0; k < NUM; k++) shadow[k] <= c_flat[k];
    end
  end

endmodule

// File: tb/tb_matmul_result_drain.sv
// Self-checking bench for matmul_result_drain: a 32-bit-output and a 16-bit-output
// instance, compared against a row-major reference model of the drained matrix.
module tb_matmul_result_drain;

  localparam int ACC_W = 32;
  localparam int M     = 2;
  localparam int N     = 2;
  localparam int NUM   = M * N;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start_a, start_b, tready;
  logic [M-1:0][N-1:0][ACC_W-1:0] c_a, c_b;
  logic busy_a, snap_a, tvalid_a, tlast_a, done_a, sat_a;
  logic busy_b, snap_b, tvalid_b, tlast_b, done_b, sat_b;
  logic [31:0] tdata_a;
  logic [15:0] tdata_b;

  matmul_result_drain #(.ACC_W(ACC_W), .OUT_W(32), .M(M), .N(N)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .C(c_a), .busy(busy_a), .snap_done(snap_a),
    .m_axis_tdata(tdata_a), .m_axis_tvalid(tvalid_a), .m_axis_tready(tready),
    .m_axis_tlast(tlast_a), .done(done_a), .sat_flag(sat_a));

  matmul_result_drain #(.ACC_W(ACC_W), .OUT_W(16), .M(M), .N(N)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .C(c_b), .busy(busy_b), .snap_done(snap_b),
    .m_axis_tdata(tdata_b), .m_axis_tvalid(tvalid_b), .m_axis_tready(tready),
    .m_axis_tlast(tlast_b), .done(done_b), .sat_flag(sat_b));

  int checks = 0;
  int fails  = 0;

  bit sel;
  logic signed [63:0] o_data;
  logic o_busy, o_snap, o_valid, o_last, o_done, o_sat;
  assign o_data  = sel ? 64'($signed(tdata_b)) : 64'($signed(tdata_a));
  assign o_busy  = sel ? busy_b   : busy_a;
  assign o_snap  = sel ? snap_b   : snap_a;
  assign o_valid = sel ? tvalid_b : tvalid_a;
  assign o_last  = sel ? tlast_b  : tlast_a;
  assign o_done  = sel ? done_b   : done_a;
  assign o_sat   = sel ? sat_b    : sat_a;

  // Reference matrix (row-major) and observations gathered by collect().
  int     mat [NUM];
  longint obs_data [$];
  bit     obs_last [$];
  int     obs_cyc  [$];
  int     done_cyc, snap_cyc, stall_err, busy_err;
  bit     busy_at_done, valid_at_done, sat_at_done;
  bit     tr_pat [7] = '{1, 0, 0, 1, 0, 1, 1};

  function automatic longint conv(input longint v, input int w);
    longint hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 1;
    lo = -hi - 1;
    if (w >= ACC_W) return v;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic bit any_clip(input int w);
    bit r = 0;
    for (int k = 0; k < NUM; k++) if (conv(longint'(mat[k]), w) != longint'(mat[k])) r = 1;
    return r;
  endfunction

  task automatic load_c();
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) begin
        c_a[i][j] = mat[i*N+j];
        c_b[i][j] = mat[i*N+j];
      end
  endtask

  task automatic fill_c(input int v);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) begin
        c_a[i][j] = v;
        c_b[i][j] = v;
      end
  endtask

  task automatic rand_mat(input int span);
    for (int k = 0; k < NUM; k++)
      mat[k] = (span == 0) ? int'($urandom) : int'($urandom_range(0, 2 * span)) - span;
  endtask

  // Observes the selected DUT from the cycle after start until done (or budget).
  // mode: 0 ready always, 1 fixed toggle pattern, 2 random ready.
  task automatic collect(input int mode, input int max_cyc, input bit mutate, input int restart_at);
    longint pd;
    bit     pl, pstall;
    obs_data.delete(); obs_last.delete(); obs_cyc.delete();
    done_cyc = -1; snap_cyc = -1; stall_err = 0; busy_err = 0; pstall = 0; pd = 0; pl = 0;
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge clk);
      start_a = 0;
      start_b = 0;
      if (o_snap && snap_cyc < 0) snap_cyc = k;
      if (pstall && (!o_valid || o_data !== pd || o_last !== pl)) stall_err++;
      if (o_done) begin
        done_cyc = k;
        busy_at_done = o_busy;
        valid_at_done = o_valid;
        sat_at_done = o_sat;
        tready = 0;
        return;
      end
      if (!o_busy) busy_err++;
      if (mutate && k == 1) fill_c(9);
      if (k == restart_at) begin
        fill_c(9);
        if (sel) start_b = 1; else start_a = 1;
      end
      case (mode)
        0: tready = 1;
        1: tready = tr_pat[(k - 1) % 7];
        default: tready = 1'($urandom_range(0, 1));
      endcase
      if (o_valid && tready) begin
        obs_data.push_back(o_data);
        obs_last.push_back(o_last);
        obs_cyc.push_back(k);
      end
      pstall = o_valid && !tready;
      pd = o_data;
      pl = o_last;
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 0;
    #1;
    checks++; if ({busy_a, snap_a, tvalid_a, tlast_a, done_a, sat_a} !== 6'b0) begin
      fails++; $display("FAIL reset_ctrl_a: got %b expected 000000", {busy_a, snap_a, tvalid_a, tlast_a, done_a, sat_a}); end
    checks++; if (tdata_a !== 32'd0) begin fails++; $display("FAIL reset_tdata_a: got %0d expected 0", tdata_a); end
    checks++; if ({busy_b, snap_b, tvalid_b, tlast_b, done_b, sat_b} !== 6'b0) begin
      fails++; $display("FAIL reset_ctrl_b: got %b expected 000000", {busy_b, snap_b, tvalid_b, tlast_b, done_b, sat_b}); end
    checks++; if (tdata_b !== 16'd0) begin fails++; $display("FAIL reset_tdata_b: got %0d expected 0", tdata_b); end
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    sel = 0;
    mat = '{1, 2, 3, 4};
    load_c();
    @(negedge clk); start_a = 1;
    collect(0, 20, 0, 0);
    checks++; if (obs_data.size() != NUM) begin fails++; $display("FAIL basic_beats: got %0d expected %0d", obs_data.size(), NUM); end
    for (int i = 0; i < obs_data.size() && i < NUM; i++) begin
      checks++; if (obs_data[i] !== conv(mat[i], 32)) begin fails++; $display("FAIL basic_data[%0d]: got %0d expected %0d", i, obs_data[i], conv(mat[i], 32)); end
      checks++; if (obs_last[i] !== (i == NUM - 1)) begin fails++; $display("FAIL basic_last[%0d]: got %0d expected %0d", i, obs_last[i], i == NUM - 1); end
      checks++; if (obs_cyc[i] != i + 1) begin fails++; $display("FAIL basic_cycle[%0d]: got %0d expected %0d", i, obs_cyc[i], i + 1); end
    end
    checks++; if (snap_cyc != 1) begin fails++; $display("FAIL basic_snap: got %0d expected 1", snap_cyc); end
    checks++; if (done_cyc != NUM + 1) begin fails++; $display("FAIL basic_done: got %0d expected %0d", done_cyc, NUM + 1); end
    checks++; if (busy_err != 0) begin fails++; $display("FAIL basic_busy_gaps: got %0d expected 0", busy_err); end
    checks++; if ({busy_at_done, valid_at_done} !== 2'b00) begin fails++; $display("FAIL basic_idle_at_done: got %b expected 00", {busy_at_done, valid_at_done}); end
    checks++; if (sat_at_done !== 1'b0) begin fails++; $display("FAIL basic_sat: got %0d expected 0", sat_at_done); end
  endtask

  task automatic test_backpressure();
    int exp_done;
    sel = 0;
    for (int it = 0; it < 3; it++) begin
      if (it == 0) mat = '{1, 2, 3, 4}; else rand_mat(0);
      load_c();
      @(negedge clk); start_a = 1;
      collect(it == 0 ? 1 : 2, 80, 0, 0);
      checks++; if (obs_data.size() != NUM) begin fails++; $display("FAIL bp%0d_beats: got %0d expected %0d", it, obs_data.size(), NUM); end
      checks++; if (stall_err != 0) begin fails++; $display("FAIL bp%0d_stable: got %0d unstable stalls expected 0", it, stall_err); end
      for (int i = 0; i < obs_data.size() && i < NUM; i++) begin
        checks++; if (obs_data[i] !== conv(mat[i], 32) || obs_last[i] !== (i == NUM - 1)) begin
          fails++; $display("FAIL bp%0d_beat[%0d]: got %0d/%0d expected %0d/%0d", it, i, obs_data[i], obs_last[i], conv(mat[i], 32), i == NUM - 1); end
      end
      exp_done = (obs_cyc.size() > 0) ? obs_cyc[obs_cyc.size() - 1] + 1 : -2;
      if (it == 0) exp_done = 8;
      checks++; if (done_cyc != exp_done) begin fails++; $display("FAIL bp%0d_done: got %0d expected %0d", it, done_cyc, exp_done); end
    end
  endtask

  task automatic test_saturate();
    bit exp_sat;
    sel = 1;
    for (int it = 0; it < 4; it++) begin
      case (it)
        0: mat = '{40000, -40000, 32767, -32768};
        1: mat = '{1, 1, 1, 1};
        default: rand_mat(100000);
      endcase
      exp_sat = any_clip(16);
      load_c();
      @(negedge clk); start_b = 1;
      collect(it < 2 ? 0 : 2, 80, 0, 0);
      checks++; if (obs_data.size() != NUM) begin fails++; $display("FAIL sat%0d_beats: got %0d expected %0d", it, obs_data.size(), NUM); end
      for (int i = 0; i < obs_data.size() && i < NUM; i++) begin
        checks++; if (obs_data[i] !== conv(mat[i], 16)) begin fails++; $display("FAIL sat%0d_data[%0d]: got %0d expected %0d", it, i, obs_data[i], conv(mat[i], 16)); end
      end
      checks++; if (sat_at_done !== exp_sat) begin fails++; $display("FAIL sat%0d_flag: got %0d expected %0d", it, sat_at_done, exp_sat); end
      @(negedge clk);
      checks++; if (sat_b !== exp_sat) begin fails++; $display("FAIL sat%0d_flag_held: got %0d expected %0d", it, sat_b, exp_sat); end
    end
  endtask

  task automatic test_snapshot();
    sel = 0;
    rand_mat(0);
    load_c();
    @(negedge clk); start_a = 1;
    collect(0, 20, 1, 0);
    checks++; if (obs_data.size() != NUM) begin fails++; $display("FAIL snap_beats: got %0d expected %0d", obs_data.size(), NUM); end
    for (int i = 0; i < obs_data.size() && i < NUM; i++) begin
      checks++; if (obs_data[i] !== conv(mat[i], 32)) begin fails++; $display("FAIL snap_data[%0d]: got %0d expected %0d", i, obs_data[i], conv(mat[i], 32)); end
    end
  endtask

  task automatic test_restart();
    sel = 0;
    rand_mat(0);
    load_c();
    @(negedge clk); start_a = 1;
    collect(0, 20, 0, 2);
    checks++; if (obs_data.size() != NUM) begin fails++; $display("FAIL ignore_beats: got %0d expected %0d", obs_data.size(), NUM); end
    checks++; if (done_cyc != NUM + 1) begin fails++; $display("FAIL ignore_done: got %0d expected %0d", done_cyc, NUM + 1); end
    for (int i = 0; i < obs_data.size() && i < NUM; i++) begin
      checks++; if (obs_data[i] !== conv(mat[i], 32)) begin fails++; $display("FAIL ignore_data[%0d]: got %0d expected %0d", i, obs_data[i], conv(mat[i], 32)); end
    end
    // Still in the done cycle: this start must be accepted.
    rand_mat(0);
    load_c();
    start_a = 1;
    collect(0, 20, 0, 0);
    checks++; if (snap_cyc != 1) begin fails++; $display("FAIL b2b_snap: got %0d expected 1", snap_cyc); end
    checks++; if (obs_data.size() != NUM || obs_cyc[0] != 1) begin fails++; $display("FAIL b2b_beats: got %0d beats expected %0d from cycle 1", obs_data.size(), NUM); end
    for (int i = 0; i < obs_data.size() && i < NUM; i++) begin
      checks++; if (obs_data[i] !== conv(mat[i], 32)) begin fails++; $display("FAIL b2b_data[%0d]: got %0d expected %0d", i, obs_data[i], conv(mat[i], 32)); end
    end
  endtask

  task automatic test_reset_midstream();
    int dn;
    sel = 0;
    rand_mat(0);
    load_c();
    @(negedge clk); start_a = 1; tready = 0;
    @(negedge clk); start_a = 0; tready = 1;
    @(negedge clk); tready = 0;
    checks++; if (64'($signed(tdata_a)) !== conv(mat[1], 32)) begin fails++; $display("FAIL rstmid_beat2: got %0d expected %0d", $signed(tdata_a), conv(mat[1], 32)); end
    @(negedge clk);
    checks++; if (tvalid_a !== 1'b1 || 64'($signed(tdata_a)) !== conv(mat[1], 32)) begin
      fails++; $display("FAIL rstmid_stall: got valid %0d data %0d expected 1/%0d", tvalid_a, $signed(tdata_a), conv(mat[1], 32)); end
    #2 rst_n = 0;
    #1;
    checks++; if ({tvalid_a, busy_a, tlast_a} !== 3'b000) begin fails++; $display("FAIL rstmid_async: got %b expected 000", {tvalid_a, busy_a, tlast_a}); end
    checks++; if (tdata_a !== 32'd0) begin fails++; $display("FAIL rstmid_tdata: got %0d expected 0", tdata_a); end
    dn = 0;
    repeat (2) begin @(negedge clk); if (done_a) dn++; end
    rst_n = 1;
    repeat (3) begin @(negedge clk); if (done_a) dn++; end
    checks++; if (dn != 0) begin fails++; $display("FAIL rstmid_no_done: got %0d done pulses expected 0", dn); end
    rand_mat(0);
    load_c();
    start_a = 1;
    collect(0, 20, 0, 0);
    checks++; if (obs_data.size() != NUM) begin fails++; $display("FAIL rstmid_fresh_beats: got %0d expected %0d", obs_data.size(), NUM); end
    checks++; if (obs_data.size() == 0 || obs_data[0] !== conv(mat[0], 32)) begin
      fails++; $display("FAIL rstmid_fresh_first: got %0d beats expected first %0d", obs_data.size(), conv(mat[0], 32)); end
    checks++; if (done_cyc != NUM + 1) begin fails++; $display("FAIL rstmid_fresh_done: got %0d expected %0d", done_cyc, NUM + 1); end
  endtask

  initial begin
    rst_n = 1; start_a = 0; start_b = 0; tready = 0; sel = 0;
    c_a = '0; c_b = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_saturate();
    test_snapshot();
    test_restart();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
